// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control unit: sequences fetch/decode/execute/memory/writeback
// and drives the datapath enables, with a memory-ready handshake and illegal-opcode flag.
module mc_control_fsm #(
  parameter int unsigned    OPW      = 6,
  parameter logic [OPW-1:0] OP_RTYPE = 6'h00,
  parameter logic [OPW-1:0] OP_LW    = 6'h23,
  parameter logic [OPW-1:0] OP_SW    = 6'h2B,
  parameter logic [OPW-1:0] OP_BEQ   = 6'h04,
  parameter logic [OPW-1:0] OP_J     = 6'h02,
  parameter logic [OPW-1:0] OP_ADDI  = 6'h08,
  parameter bit             EN_JUMP  = 1'b1,
  parameter bit             EN_ADDI  = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemToReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic           illegal_op,
  output logic [3:0]     state
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRwb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11
  } state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           op_jump, op_addi;

  assign op_jump = EN_JUMP && (opcode == OP_J);
  assign op_addi = EN_ADDI && (opcode == OP_ADDI);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    op_d    = op_q;
    case (state_q)
      StFetch:   state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        op_d = opcode;
        if (opcode == OP_LW || opcode == OP_SW) state_d = StMemAddr;
        else if (opcode == OP_RTYPE)            state_d = StExec;
        else if (opcode == OP_BEQ)              state_d = StBranch;
        else if (op_jump)                       state_d = StJump;
        else if (op_addi)                       state_d = StAddiEx;
        else                                    state_d = StFetch;
      end
      // Load/store choice uses the opcode captured in DECODE, not the live IR field.
      StMemAddr: state_d = (op_q == OP_LW) ? StMemRd : StMemWr;
      StMemRd:   state_d = mem_ready ? StMemWb : StMemRd;
      StMemWb:   state_d = StFetch;
      StMemWr:   state_d = mem_ready ? StFetch : StMemWr;
      StExec:    state_d = StRwb;
      StRwb:     state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJump:    state_d = StFetch;
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    illegal_op  = 1'b0;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: begin
        ALUSrcB    = 2'b11;
        illegal_op = (state_d == StFetch);
      end
      StMemAddr: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StExec: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      StRwb: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      StBranch: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      StJump: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      StAddiEx: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      StAddiWb:  RegWrite = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle expected state/outputs go through a scoreboard queue.
module tb_mc_control_fsm;

  logic       clk;
  logic       rst_n, rst_nj;
  logic [5:0] opcode, op_nj;
  logic       mem_ready;

  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst;
  logic       RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  logic       n_PCWrite, n_PCWriteCond, n_IorD, n_MemRead, n_MemWrite, n_IRWrite;
  logic       n_MemToReg, n_RegDst, n_RegWrite, n_ALUSrcA, n_illegal_op;
  logic [1:0] n_ALUSrcB, n_ALUOp, n_PCSource;
  logic [3:0] n_state;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .state(state)
  );

  mc_control_fsm #(.EN_JUMP(1'b0)) dut_nj (
    .clk(clk), .rst_n(rst_nj), .opcode(op_nj), .mem_ready(mem_ready),
    .PCWrite(n_PCWrite), .PCWriteCond(n_PCWriteCond), .IorD(n_IorD), .MemRead(n_MemRead),
    .MemWrite(n_MemWrite), .IRWrite(n_IRWrite), .MemToReg(n_MemToReg), .RegDst(n_RegDst),
    .RegWrite(n_RegWrite), .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ALUOp(n_ALUOp),
    .PCSource(n_PCSource), .illegal_op(n_illegal_op), .state(n_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] o;
    bit          nj;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic bit legal(input logic [5:0] op, input bit en_j);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
           (op == 6'h08) || (en_j && op == 6'h02);
  endfunction

  // Bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemToReg RegDst RegWrite
  //            ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] illegal_op
  function automatic logic [16:0] model(input logic [3:0] st, input logic mr, input logic ill);
    logic pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa;
    logic [1:0] sb_, aop, pcs;
    {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa} = '0;
    sb_ = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; sb_ = 2'b01; irw = mr; pcw = mr; end
      4'd1:  sb_ = 2'b11;
      4'd2:  begin sa = 1; sb_ = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin sa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin sa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin sa = 1; sb_ = 2'b10; end
      4'd11: rw = 1;
      default: ;
    endcase
    return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb_, aop, pcs, ill};
  endfunction

  task automatic step(input bit nj, input logic rstv, input logic mr, input logic [5:0] op,
                      input logic [3:0] st);
    exp_t        e;
    logic [3:0]  obs_st;
    logic [16:0] obs_o;
    logic        ill;
    if (nj) begin rst_nj = rstv; op_nj = op; end
    else    begin rst_n = rstv;  opcode = op; end
    mem_ready = mr;
    ill  = (st == 4'd1) && !legal(op, !nj);
    e.st = st;
    e.o  = model(st, mr, ill);
    e.nj = nj;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    if (e.nj) begin
      obs_st = n_state;
      obs_o  = {n_PCWrite, n_PCWriteCond, n_IorD, n_MemRead, n_MemWrite, n_IRWrite, n_MemToReg,
                n_RegDst, n_RegWrite, n_ALUSrcA, n_ALUSrcB, n_ALUOp, n_PCSource, n_illegal_op};
    end else begin
      obs_st = state;
      obs_o  = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};
    end
    checks++;
    assert (obs_st === e.st) else begin
      errors++;
      $error("FAIL state(nj=%0d) got %0d want %0d", e.nj, obs_st, e.st);
    end
    checks++;
    assert (obs_o === e.o) else begin
      errors++;
      $error("FAIL outputs(nj=%0d,state=%0d) got %b want %b", e.nj, e.st, obs_o, e.o);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rst_nj = 1'b0; opcode = 6'h00; op_nj = 6'h00; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // LW into a memory wait, then reset held for two edges
    step(0, 1, 1, 6'h23, 4'd0);
    step(0, 1, 1, 6'h23, 4'd1);
    step(0, 1, 1, 6'h3F, 4'd2);
    step(0, 1, 0, 6'h3F, 4'd3);
    step(0, 0, 0, 6'h3F, 4'd3);
    step(0, 0, 0, 6'h3F, 4'd0);
    // R-type
    step(0, 1, 1, 6'h00, 4'd0);
    step(0, 1, 1, 6'h00, 4'd1);
    step(0, 1, 1, 6'h00, 4'd6);
    step(0, 1, 1, 6'h00, 4'd7);
    // LW with three wait cycles; live opcode changes after DECODE
    step(0, 1, 1, 6'h23, 4'd0);
    step(0, 1, 1, 6'h23, 4'd1);
    step(0, 1, 1, 6'h2B, 4'd2);
    step(0, 1, 0, 6'h2B, 4'd3);
    step(0, 1, 0, 6'h2B, 4'd3);
    step(0, 1, 0, 6'h2B, 4'd3);
    step(0, 1, 1, 6'h2B, 4'd3);
    step(0, 1, 1, 6'h2B, 4'd4);
    // SW then BEQ
    step(0, 1, 1, 6'h2B, 4'd0);
    step(0, 1, 1, 6'h2B, 4'd1);
    step(0, 1, 1, 6'h23, 4'd2);
    step(0, 1, 1, 6'h23, 4'd5);
    step(0, 1, 1, 6'h04, 4'd0);
    step(0, 1, 1, 6'h04, 4'd1);
    step(0, 1, 1, 6'h04, 4'd8);
    // J then ADDI
    step(0, 1, 1, 6'h02, 4'd0);
    step(0, 1, 1, 6'h02, 4'd1);
    step(0, 1, 1, 6'h02, 4'd9);
    step(0, 1, 1, 6'h08, 4'd0);
    step(0, 1, 1, 6'h08, 4'd1);
    step(0, 1, 1, 6'h08, 4'd10);
    step(0, 1, 1, 6'h08, 4'd11);
    // SW with a write wait, fetch with a wait
    step(0, 1, 0, 6'h2B, 4'd0);
    step(0, 1, 1, 6'h2B, 4'd0);
    step(0, 1, 1, 6'h2B, 4'd1);
    step(0, 1, 0, 6'h2B, 4'd2);
    step(0, 1, 0, 6'h2B, 4'd5);
    step(0, 1, 1, 6'h2B, 4'd5);
    // Illegal opcode
    step(0, 1, 1, 6'h3F, 4'd0);
    step(0, 1, 1, 6'h3F, 4'd1);
    step(0, 1, 1, 6'h3F, 4'd0);
    step(0, 1, 1, 6'h3F, 4'd1);
    step(0, 1, 0, 6'h00, 4'd0);

    // Jump disabled: 6'h02 is illegal, ADDI still decodes
    rst_n = 1'b0;
    step(1, 1, 1, 6'h02, 4'd0);
    step(1, 1, 1, 6'h02, 4'd1);
    step(1, 1, 1, 6'h02, 4'd0);
    step(1, 1, 1, 6'h08, 4'd1);
    step(1, 1, 1, 6'h08, 4'd10);
    step(1, 1, 1, 6'h08, 4'd11);
    step(1, 1, 1, 6'h08, 4'd0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle MIPS main control unit; next generation of the single-cycle opcode decoder. Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives datapath enables cycle by cycle. Adds a memory ready handshake, jump and addi support, and illegal-opcode detection. Sits between the instruction register opcode field and the multi-cycle datapath, shared memory and PC logic.

Parameters:
OPW, 6, opcode field width
OP_RTYPE, 6'h00, R-format opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-equal opcode
OP_J, 6'h02, jump opcode; decoded only if EN_JUMP=1
OP_ADDI, 6'h08, add-immediate opcode; decoded only if EN_ADDI=1
EN_JUMP, 1, 1 enables jump decode
EN_ADDI, 1, 1 enables addi decode

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  OPW  IR[31:26]; sampled only in DECODE
mem_ready  in  1  memory has completed the current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero
IorD  out  1  0=PC address, 1=ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemToReg  out  1  0=ALUOut, 1=MDR to register file
RegDst  out  1  0=rt, 1=rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=rs
ALUSrcB  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=shifted imm
ALUOp  out  2  00=add, 01=sub, 10=funct field
PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target
illegal_op  out  1  one-cycle pulse on undefined opcode
state  out  4  current state encoding (debug)

Behaviour:
- Synchronous reset: on rising clk with rst_n=0, state<=FETCH(0). Reset wins over every other transition, including mid-memory-wait. No in-flight request is retained.
- Outputs are Moore: pure decode of the state register. The only exceptions are PCWrite and IRWrite in FETCH, which are qualified by mem_ready. All unlisted outputs are 0 in a given state.
- States, encodings and assertions:
  - FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=mem_ready, PCWrite=mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode: LW/SW->MEMADDR, RTYPE->EXEC, BEQ->BRANCH, J->JUMP, ADDI->ADDI_EX. Any other opcode (or a disabled J/ADDI) -> FETCH with illegal_op=1 for this cycle only.
  - MEMADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMRD if opcode latched in DECODE was LW, else MEMWR.
  - MEMRD(3): MemRead=1, IorD=1. Stay while mem_ready=0; go to MEMWB when mem_ready=1.
  - MEMWB(4): RegWrite=1, MemToReg=1, RegDst=0. Next: FETCH.
  - MEMWR(5): MemWrite=1, IorD=1. Stay while mem_ready=0; go to FETCH when mem_ready=1.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: RWB.
  - RWB(7): RegWrite=1, RegDst=1, MemToReg=0. Next: FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
  - JUMP(9): PCWrite=1, PCSource=10. Next: FETCH.
  - ADDI_EX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDI_WB.
  - ADDI_WB(11): RegWrite=1, RegDst=0, MemToReg=0. Next: FETCH.
- Encodings 12-15 are unreachable. If entered, they drive all outputs 0 and go to FETCH on the next edge.
- The opcode is captured into an internal OPW-bit register in DECODE. Later states use the captured value, not the live port.
- Cycle counts with mem_ready tied to 1: R=4, LW=5, SW=4, BEQ=3, J=3, ADDI=4, illegal=2.
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. mem_ready is ignored in all other states.
- MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.

Test Plan:
- Reset: hold rst_n=0 for 2 edges while in MEMRD -> state=0, MemRead=1, IorD=0, RegWrite=0, illegal_op=0.
- R-type, mem_ready=1, opcode=6'h00 -> states 0,1,6,7,0. RegWrite=1 with RegDst=1 only in state 7. ALUOp=10 in state 6.
- LW with wait: opcode=6'h23, mem_ready low 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0 (8 cycles). MemToReg=1 in state 4.
- SW and BEQ back to back -> SW gives states 0,1,2,5,0 with MemWrite=1 only in 5. BEQ gives 0,1,8,0 with PCWriteCond=1, ALUOp=01, PCSource=01 in 8.
- J and ADDI -> J gives 0,1,9,0 with PCWrite=1, PCSource=10. ADDI (6'h08) gives 0,1,10,11,0 with RegDst=0.
- Illegal: opcode=6'h3F, and separately EN_JUMP=0 with opcode=6'h02 -> DECODE goes to FETCH, illegal_op=1 for exactly one cycle, no RegWrite/MemWrite/PCWrite asserted.
